// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_multi
// Brief    : SPI master, selectable slave, CPOL/CPHA, bit order, CS-held bursts.
// Revision : 1.0
// ============================================================================
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              hold_cs,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] ss_n
);

    localparam int HALF_W = $clog2(2 * DATA_W);
    localparam logic [HALF_W-1:0] c_LAST_HALF = HALF_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_XFER  = 3'd2,
        S_TRAIL = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [HALF_W-1:0]   r_half;
    logic [CS_W-1:0]     r_sel;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb;
    logic                r_hold;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx_sh;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_busy;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_ss_n;

    logic                w_phase_end;
    logic                w_edge;
    logic [HALF_W-1:0]   w_new_half;
    logic                w_leading;
    logic                w_sample;
    logic                w_shift;
    logic                w_can_start;
    logic                w_cpha_new;
    logic [NUM_CS-1:0]   w_sel_mask;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    assign w_phase_end = (r_cnt == r_div);
    // An sclk edge opens every XFER half-period, the first one on leaving LEAD.
    assign w_edge      = w_phase_end &&
                         ((r_state == S_LEAD) ||
                          ((r_state == S_XFER) && (r_half != c_LAST_HALF)));
    assign w_new_half  = (r_state == S_LEAD) ? '0 : r_half + 1'b1;
    assign w_leading   = ~w_new_half[0];
    assign w_sample    = w_edge && (w_leading ^ r_cpha);
    assign w_shift     = w_edge && !(w_leading ^ r_cpha) && (w_new_half != c_LAST_HALF);
    assign w_can_start = ((r_state == S_IDLE) || (r_state == S_HOLD)) && start && !abort &&
                         (32'(cs_sel) < NUM_CS);
    assign w_cpha_new  = (r_state == S_IDLE) ? cpha : r_cpha;
    assign w_sel_mask  = ~(NUM_CS'(1) << cs_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_half     <= '0;
            r_sel      <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_hold     <= 1'b0;
            r_tx       <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= '1;
        end else begin
            r_rx_valid <= 1'b0;

            if (w_sample) begin
                r_rx_sh <= r_lsb ? {miso, r_rx_sh[DATA_W-1:1]} : {r_rx_sh[DATA_W-2:0], miso};
            end
            if (w_shift) begin
                r_mosi <= first_bit(r_tx, r_lsb);
                r_tx   <= shift_out(r_tx, r_lsb);
            end

            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_ss_n  <= '1;
                r_sclk  <= r_cpol;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_HOLD: begin
                        if (w_can_start) begin
                            // Slave, mode and rate only change at the start of a burst.
                            if (r_state == S_IDLE) begin
                                r_sel  <= cs_sel;
                                r_cpol <= cpol;
                                r_cpha <= cpha;
                                r_div  <= clk_div;
                                r_ss_n <= w_sel_mask;
                                r_sclk <= cpol;
                            end
                            r_lsb   <= lsb_first;
                            r_hold  <= hold_cs;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_LEAD;
                            if (!w_cpha_new) begin
                                r_mosi <= first_bit(tx_data, lsb_first);
                                r_tx   <= shift_out(tx_data, lsb_first);
                            end else begin
                                r_tx   <= tx_data;
                            end
                        end
                    end
                    S_LEAD: begin
                        if (w_phase_end) begin
                            r_cnt   <= '0;
                            r_half  <= '0;
                            r_sclk  <= ~r_sclk;
                            r_state <= S_XFER;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_XFER: begin
                        if (w_phase_end) begin
                            r_cnt <= '0;
                            if (r_half == c_LAST_HALF) begin
                                r_state <= S_TRAIL;
                            end else begin
                                r_half <= r_half + 1'b1;
                                r_sclk <= ~r_sclk;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_TRAIL: begin
                        if (w_phase_end) begin
                            r_cnt      <= '0;
                            r_rx_data  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                            r_busy     <= 1'b0;
                            if (r_hold) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_state <= S_IDLE;
                                r_ss_n  <= '1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ss_n  <= '1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign ss_n     = r_ss_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_multi
// Brief    : Randomised and directed scoreboard bench for spi_master_multi.
// Revision : 1.0
// ============================================================================
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] cs_sel = '0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, hold_cs = 1'b0;
    logic [7:0] clk_div = '0;
    logic [7:0] tx_data = '0;
    logic [7:0] rx_data;
    logic       rx_valid, busy, sclk, mosi, miso;
    logic [3:0] ss_n;
    logic       miso_one = 1'b0;

    assign miso = miso_one ? 1'b1 : mosi;

    spi_master_multi #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .hold_cs(hold_cs),
        .clk_div(clk_div), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    // Five-slave instance so that an out-of-range index is representable.
    logic       start2 = 1'b0;
    logic [2:0] cs_sel2 = '0;
    logic [7:0] rx_data2;
    logic       rx_valid2, busy2, sclk2, mosi2;
    logic [4:0] ss_n2;

    spi_master_multi #(.DATA_W(8), .NUM_CS(5), .DIV_W(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .cs_sel(cs_sel2),
        .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .hold_cs(1'b0),
        .clk_div(8'd0), .tx_data(8'h5A), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .busy(busy2), .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .ss_n(ss_n2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int         cyc_q[$];
    logic [7:0] last_rx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [7:0] d;
        int         c;
        if (!reset && rx_valid) begin
            if (exp_q.size() == 0) begin
                check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
            end else begin
                d = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(d));
                check("rx_latency", cyc, c);
            end
        end
    end

    // One word: expectation = loopback word (or all ones with miso tied high),
    // delivered (2*8+2)*(div+1) cycles after the accepting edge.
    task automatic run_word(input logic [1:0] sel, input logic cp, input logic ph,
                            input logic lsb, input logic hold, input logic [7:0] div,
                            input logic [7:0] tx, input logic m1, input logic from_hold);
        logic [3:0] mask;
        logic       prev;
        int         edges;
        int         ss_bad;
        mask = 4'hF;
        mask[sel] = 1'b0;
        @(negedge clk);
        if (from_hold) check("ss_n_in_hold", 32'(ss_n), 32'(mask));
        miso_one  = m1;
        start     = 1'b1;
        tx_data   = tx;
        lsb_first = lsb;
        hold_cs   = hold;
        if (from_hold) begin
            cs_sel  = 2'($urandom);
            cpol    = 1'($urandom);
            cpha    = 1'($urandom);
            clk_div = 8'($urandom);
        end else begin
            cs_sel  = sel;
            cpol    = cp;
            cpha    = ph;
            clk_div = div;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(m1 ? 8'hFF : tx);
        cyc_q.push_back(cyc + 18 * (int'(div) + 1));
        start     = 1'b0;
        tx_data   = 8'($urandom);
        lsb_first = 1'($urandom);
        hold_cs   = 1'($urandom);
        cpol      = 1'($urandom);
        cpha      = 1'($urandom);
        clk_div   = 8'($urandom);
        cs_sel    = 2'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        edges  = 0;
        ss_bad = 0;
        prev   = sclk;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sclk !== prev) edges++;
            prev = sclk;
            if (busy && ss_n !== mask) ss_bad++;
            if (!busy) break;
        end
        check("busy_done", 32'(busy), 32'd0);
        check("sclk_edges", edges, 16);
        check("ss_n_during", ss_bad, 0);
        check("ss_n_after", 32'(ss_n), hold ? 32'(mask) : 32'hF);
        check("sclk_idle", 32'(sclk), 32'(cp));
        last_rx = m1 ? 8'hFF : tx;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   edges;
        logic prev;
        logic poked;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ss_n", 32'(ss_n), 32'hF);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Mode 0 basic word, then modes 1..3 and constant-high miso.
        run_word(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'hA5, 1'b0, 1'b0);
        run_word(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0, 1'b0);
        run_word(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'hF0, 1'b0, 1'b0);
        run_word(2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'h0F, 1'b0, 1'b0);
        run_word(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h5A, 1'b0, 1'b0);
        run_word(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'hF0, 1'b0, 1'b0);
        run_word(2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'h0F, 1'b0, 1'b0);
        run_word(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h12, 1'b1, 1'b0);

        // Three-word burst on slave 2; later words get junk mode/rate inputs.
        run_word(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'h11, 1'b0, 1'b0);
        run_word(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'h22, 1'b0, 1'b1);
        run_word(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'h33, 1'b0, 1'b1);

        // Abort at the fifth sclk edge; a stray start while busy is ignored.
        @(negedge clk);
        miso_one = 1'b0; start = 1'b1; cs_sel = 2'd1; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; hold_cs = 1'b0; clk_div = 8'd1; tx_data = 8'hC3;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        poked = 1'b0;
        prev  = sclk;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sclk !== prev) edges++;
            prev = sclk;
            if (edges == 2 && !poked) begin
                poked  = 1'b1;
                start  = 1'b1;
                cs_sel = 2'd3;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("start_while_busy_ss_n", 32'(ss_n), 32'hD);
            end
            if (edges == 5) break;
        end
        check("abort_edge_reached", edges, 5);
        abort  = 1'b1;
        start  = 1'b1;
        cs_sel = 2'd2;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ss_n", 32'(ss_n), 32'hF);
        check("abort_sclk", 32'(sclk), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_start_ignored", 32'(busy), 32'd0);
        check("abort_rx_data_kept", 32'(rx_data), 32'(last_rx));

        // Reset in the middle of XFER.
        @(negedge clk);
        start = 1'b1; cs_sel = 2'd0; cpol = 1'b1; cpha = 1'b0;
        lsb_first = 1'b0; hold_cs = 1'b0; clk_div = 8'd1; tx_data = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_ss_n", 32'(ss_n), 32'hF);
        check("midreset_sclk", 32'(sclk), 32'd0);
        check("midreset_mosi", 32'(mosi), 32'd0);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        last_rx = '0;
        run_word(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'h3C, 1'b0, 1'b0);

        // Out-of-range slave index on the five-slave instance.
        @(negedge clk);
        start2  = 1'b1;
        cs_sel2 = 3'd5;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("bad_sel_busy", 32'(busy2), 32'd0);
        check("bad_sel_ss_n", 32'(ss_n2), 32'h1F);
        @(negedge clk);
        start2  = 1'b1;
        cs_sel2 = 3'd4;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("good_sel_busy", 32'(busy2), 32'd1);
        check("good_sel_ss_n", 32'(ss_n2), 32'h0F);

        // Randomised single words.
        for (int i = 0; i < 16; i++) begin
            run_word(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                     8'($urandom_range(3, 0)), 8'($urandom),
                     ($urandom_range(7, 0) == 0), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
